// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter and address decoder for the uncached slaves.
// One transaction is in flight at a time: IDLE grants, BUSY waits on the slave, RESP returns.
module bus_arbiter #(
    parameter logic [31:0] rom_base_addr   = 32'h0000_0000,
    parameter logic [31:0] rom_top_addr    = 32'h0000_0080,
    parameter logic [31:0] uart_base_addr  = 32'h0100_0000,
    parameter logic [31:0] uart_top_addr   = 32'h0100_0004,
    parameter logic [31:0] clint_base_addr = 32'h0200_0000,
    parameter logic [31:0] clint_top_addr  = 32'h0200_C000,
    parameter logic [31:0] axi_base_addr   = 32'h8000_0000,
    parameter logic [31:0] axi_top_addr    = 32'h9000_0000,
    parameter int unsigned timeout_cycles  = 1023
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    input  logic [1:0]    req_instr,
    input  logic [63:0]   req_addr,
    input  logic [63:0]   req_wdata,
    input  logic [7:0]    req_wstrb,
    output logic [1:0]    rsp_ready,
    output logic [63:0]   rsp_rdata,
    output logic [1:0]    rsp_error,
    output logic [3:0]    slv_valid,
    output logic          slv_instr,
    output logic [31:0]   slv_addr,
    output logic [31:0]   slv_wdata,
    output logic [3:0]    slv_wstrb,
    input  logic [3:0]    slv_ready,
    input  logic [127:0]  slv_rdata
);

    localparam int cnt_w = $clog2(timeout_cycles + 1);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout_cycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             gnt_q;
    logic [cnt_w-1:0] cnt;

    logic             gnt;
    logic [31:0]      grant_addr;
    logic [3:0]       hit_oh;
    logic [31:0]      sel_rdata;
    logic             slave_ack;

    // Unsigned window test written as an offset compare so a zero base needs no special case.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] top);
        return (addr - base) < (top - base);
    endfunction

    function automatic logic [1:0] onehot2(input logic m);
        return m ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [63:0] place(input logic m, input logic [31:0] d);
        return m ? {d, 32'h0} : {32'h0, d};
    endfunction

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        gnt        = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        grant_addr = gnt ? req_addr[63:32] : req_addr[31:0];
        hit_oh     = 4'b0000;
        if (in_window(grant_addr, rom_base_addr, rom_top_addr))
            hit_oh = 4'b0001;
        else if (in_window(grant_addr, uart_base_addr, uart_top_addr))
            hit_oh = 4'b0010;
        else if (in_window(grant_addr, clint_base_addr, clint_top_addr))
            hit_oh = 4'b0100;
        else if (in_window(grant_addr, axi_base_addr, axi_top_addr))
            hit_oh = 4'b1000;
    end

    // slv_valid is only non-zero in BUSY, so it also masks stray ready from other slaves.
    always_comb begin
        sel_rdata = '0;
        for (int s = 0; s < 4; s++)
            if (slv_valid[s])
                sel_rdata = sel_rdata | slv_rdata[32*s +: 32];
    end

    assign slave_ack = |(slv_ready & slv_valid);

    // NOTE: sequential state uses non-blocking assignments only; the async reset clears
    // every register so a mid-transaction reset drops slv_valid without waiting for a clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            gnt_q      <= 1'b0;
            cnt        <= '0;
            rsp_ready  <= '0;
            rsp_rdata  <= '0;
            rsp_error  <= '0;
            slv_valid  <= '0;
            slv_instr  <= 1'b0;
            slv_addr   <= '0;
            slv_wdata  <= '0;
            slv_wstrb  <= '0;
        end else begin
            rsp_ready <= '0;
            rsp_error <= '0;
            rsp_rdata <= '0;
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        gnt_q     <= gnt;
                        slv_instr <= req_instr[gnt];
                        slv_addr  <= grant_addr;
                        slv_wdata <= gnt ? req_wdata[63:32] : req_wdata[31:0];
                        slv_wstrb <= gnt ? req_wstrb[7:4] : req_wstrb[3:0];
                        if (hit_oh != 4'b0000) begin
                            slv_valid <= hit_oh;
                            cnt       <= '0;
                            state     <= BUSY;
                        end else begin
                            rsp_ready <= onehot2(gnt);
                            rsp_error <= onehot2(gnt);
                            state     <= RESP;
                        end
                    end
                end
                BUSY: begin
                    if (slave_ack) begin
                        slv_valid <= '0;
                        rsp_ready <= onehot2(gnt_q);
                        rsp_rdata <= place(gnt_q, sel_rdata);
                        state     <= RESP;
                    end else if (cnt == cnt_last) begin
                        slv_valid <= '0;
                        rsp_ready <= onehot2(gnt_q);
                        rsp_error <= onehot2(gnt_q);
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    last_grant <= gnt_q;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with hand-computed expectations.
// Cycle n is observed 1 time unit after the n-th rising edge following request setup.
module tb_bus_arbiter;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_instr = '0;
    logic [63:0]   req_addr  = '0;
    logic [63:0]   req_wdata = '0;
    logic [7:0]    req_wstrb = '0;
    logic [1:0]    rsp_ready;
    logic [63:0]   rsp_rdata;
    logic [1:0]    rsp_error;
    logic [3:0]    slv_valid;
    logic          slv_instr;
    logic [31:0]   slv_addr;
    logic [31:0]   slv_wdata;
    logic [3:0]    slv_wstrb;
    logic [3:0]    slv_ready = '0;
    logic [127:0]  slv_rdata = '0;

    int checks   = 0;
    int failures = 0;

    bus_arbiter #(.timeout_cycles(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_instr (req_instr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .slv_valid (slv_valid),
        .slv_instr (slv_instr),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_wstrb (slv_wstrb),
        .slv_ready (slv_ready),
        .slv_rdata (slv_rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request from master m; the DUT samples it at the next edge.
    task automatic request(input int m, input logic [31:0] addr, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input logic instr);
        req_valid = '0;
        req_instr = '0;
        req_valid[m] = 1'b1;
        req_instr[m] = instr;
        req_addr[32*m +: 32]  = addr;
        req_wdata[32*m +: 32] = wdata;
        req_wstrb[4*m +: 4]   = wstrb;
    endtask

    task automatic drop_all();
        req_valid = '0;
        slv_ready = '0;
    endtask

    initial begin
        int  n;
        bit  done;
        logic [1:0] seen_rsp;

        repeat (2) tick();
        check("reset_outputs", {rsp_ready, rsp_error, slv_valid, slv_instr, slv_wstrb}, '0);
        check("reset_data", {rsp_rdata, slv_addr, slv_wdata}, '0);
        reset = 1'b1;
        tick();

        // UART read by the data master, ready at cycle 3.
        request(1, 32'h0100_0000, 4'b0000, 32'h0, 1'b0);
        tick();
        check("uart_valid_c1", slv_valid, 4'b0010);
        check("uart_addr", slv_addr, 32'h0100_0000);
        tick();
        check("uart_valid_c2", slv_valid, 4'b0010);
        tick();
        check("uart_valid_c3", slv_valid, 4'b0010);
        check("uart_no_rsp_c3", rsp_ready, 2'b00);
        slv_ready[1] = 1'b1;
        slv_rdata[63:32] = 32'h0000_0055;
        tick();
        check("uart_rsp_ready", rsp_ready, 2'b10);
        check("uart_rdata", rsp_rdata[63:32], 32'h0000_0055);
        check("uart_error", rsp_error, 2'b00);
        check("uart_valid_off", slv_valid, 4'b0000);
        drop_all();
        tick();
        check("uart_rsp_one_cycle", rsp_ready, 2'b00);

        // Fresh reset, then a tie: data wins first, fetch next, data again on a repeat tie.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        slv_ready = 4'b1111;
        slv_rdata = {32'hAAAA_0003, 32'hCCCC_0002, 32'h5555_0001, 32'h1111_0000};
        req_valid = 2'b11;
        req_instr = 2'b01;
        req_addr  = {32'h0200_0000, 32'h0000_0040};
        req_wstrb = '0;
        tick();
        check("tie_first_clint", slv_valid, 4'b0100);
        tick();
        check("tie_rsp_data", rsp_ready, 2'b10);
        check("tie_rdata_data", rsp_rdata, {32'hCCCC_0002, 32'h0});
        req_valid = 2'b01;
        tick();
        check("tie_dead_cycle", {rsp_ready, slv_valid}, '0);
        tick();
        check("tie_then_rom", slv_valid, 4'b0001);
        check("tie_fetch_instr", slv_instr, 1'b1);
        tick();
        check("tie_rsp_fetch", rsp_ready, 2'b01);
        check("tie_rdata_fetch", rsp_rdata, {32'h0, 32'h1111_0000});
        req_valid = 2'b11;
        tick();
        tick();
        check("tie_repeat_data", slv_valid, 4'b0100);
        tick();
        check("tie_repeat_rsp", rsp_ready, 2'b10);
        drop_all();
        tick();

        // Unmapped write from the data master.
        request(1, 32'h3000_0000, 4'b1111, 32'hDEAD_BEEF, 1'b0);
        tick();
        check("unmapped_no_valid", slv_valid, 4'b0000);
        check("unmapped_rsp", rsp_ready, 2'b10);
        check("unmapped_err", rsp_error, 2'b10);
        check("unmapped_rdata", rsp_rdata, 64'h0);
        drop_all();
        tick();

        // AXI timeout: slave never ready, slv_valid[3] should stay up for 8 cycles.
        request(1, 32'h8000_0010, 4'b0000, 32'h0, 1'b0);
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (rsp_ready != 2'b00) done = 1'b1;
            else if (slv_valid == 4'b1000) n++;
        end
        check("timeout_reached", done, 1'b1);
        check("timeout_cycles", n, 8);
        check("timeout_err", rsp_error, 2'b10);
        check("timeout_rdata", rsp_rdata, 64'h0);
        drop_all();
        tick();

        // Ready on the eighth BUSY cycle still counts as success.
        request(1, 32'h8000_0010, 4'b0000, 32'h0, 1'b0);
        repeat (8) tick();
        check("late_valid_c8", slv_valid, 4'b1000);
        slv_ready[3] = 1'b1;
        slv_rdata[127:96] = 32'hFACE_0008;
        tick();
        check("late_rsp", rsp_ready, 2'b10);
        check("late_err", rsp_error, 2'b00);
        check("late_rdata", rsp_rdata[63:32], 32'hFACE_0008);
        drop_all();
        tick();

        // Window boundaries.
        request(1, 32'h0200_BFFC, 4'b0011, 32'h1234_5678, 1'b0);
        tick();
        check("clint_top_valid", slv_valid, 4'b0100);
        check("clint_wstrb", slv_wstrb, 4'b0011);
        check("clint_wdata", slv_wdata, 32'h1234_5678);
        slv_ready[2] = 1'b1;
        tick();
        check("clint_top_rsp", rsp_ready, 2'b10);
        drop_all();
        tick();

        request(1, 32'h0200_C000, 4'b0000, 32'h0, 1'b0);
        tick();
        check("clint_past_top_err", {rsp_ready, rsp_error, slv_valid}, {2'b10, 2'b10, 4'b0000});
        drop_all();
        tick();

        request(0, 32'h0000_007F, 4'b0000, 32'h0, 1'b1);
        tick();
        check("rom_last_byte", slv_valid, 4'b0001);
        slv_ready[0] = 1'b1;
        tick();
        check("rom_last_rsp", {rsp_ready, rsp_error}, {2'b01, 2'b00});
        drop_all();
        tick();

        request(0, 32'h0000_0080, 4'b0000, 32'h0, 1'b1);
        tick();
        check("rom_past_top_err", {rsp_ready, rsp_error, slv_valid}, {2'b01, 2'b01, 4'b0000});
        drop_all();
        tick();

        // Reset in the middle of BUSY: slv_valid falls at once and no response follows.
        request(0, 32'h0000_0040, 4'b0000, 32'h0, 1'b1);
        tick();
        tick();
        check("rst_pre_valid", slv_valid, 4'b0001);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_valid", slv_valid, 4'b0000);
        drop_all();
        tick();
        reset = 1'b1;
        seen_rsp = '0;
        repeat (12) begin
            tick();
            seen_rsp = seen_rsp | rsp_ready;
        end
        check("rst_no_rsp", seen_rsp, 2'b00);

        request(0, 32'h0000_0000, 4'b0000, 32'h0, 1'b1);
        slv_rdata[31:0] = 32'h0BAD_F00D;
        tick();
        check("post_rst_valid", slv_valid, 4'b0001);
        slv_ready[0] = 1'b1;
        tick();
        check("post_rst_rsp", {rsp_ready, rsp_error}, {2'b01, 2'b00});
        check("post_rst_rdata", rsp_rdata, {32'h0, 32'h0BAD_F00D});
        drop_all();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, single-outstanding bus arbiter and address decoder placed between the core's fetch and data memory ports and the uncached slaves (boot ROM, UART, CLINT, AXI bridge). It grants one request at a time using round-robin priority, decodes the latched address against the slave windows, and drives a one-hot valid to the selected slave. It returns the slave's read data, or an error response for unmapped addresses or slave timeout. ITIM/DTIM accesses are resolved upstream and never reach this block.

## Interface
- rom_base_addr, 32'h0, ROM window start (inclusive)
- rom_top_addr, 32'h80, ROM window end (exclusive)
- uart_base_addr, 32'h1000000, UART window start
- uart_top_addr, 32'h1000004, UART window end
- clint_base_addr, 32'h2000000, CLINT window start
- clint_top_addr, 32'h200C000, CLINT window end
- axi_base_addr, 32'h80000000, AXI window start
- axi_top_addr, 32'h90000000, AXI window end
- timeout_cycles, 1023, max BUSY cycles waiting for slave ready (>=1)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  2  request per master; bit0 fetch, bit1 data; held until rsp_ready
- req_instr  in  2  instruction-access flag per master
- req_addr  in  64  byte address; master m at [32m+31:32m]
- req_wdata  in  64  write data; master m at [32m+31:32m]
- req_wstrb  in  8  byte strobes, master m at [4m+3:4m]; 0 = read
- rsp_ready  out  2  one-cycle response strobe per master
- rsp_rdata  out  64  read data per master slice; valid only with rsp_ready
- rsp_error  out  2  error flag, valid only with rsp_ready
- slv_valid  out  4  one-hot select; bit0 ROM, bit1 UART, bit2 CLINT, bit3 AXI
- slv_instr  out  1  latched instr flag
- slv_addr  out  32  latched address
- slv_wdata  out  32  latched write data
- slv_wstrb  out  4  latched strobes
- slv_ready  in  4  per-slave completion
- slv_rdata  in  128  per-slave read data; slave s at [32s+31:32s]

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any req_valid, grant one master. Tie: the master not granted last wins; after reset the data master (bit1) wins the first tie. Latch the master's instr, addr, wdata, wstrb and the granted index into slv_* registers.
- Decode (in IDLE, on req_addr): unsigned hit when base <= addr < top. Priority on overlap: ROM > UART > CLINT > AXI.
- On hit: next state BUSY; registered slv_valid = one-hot of the hit; timeout counter = 0.
- On miss: next state RESP with error = 1 and data = 0.
- BUSY: hold slv_valid and slv_* stable.
  - slv_ready of the selected slave high: capture that slave's rdata, error = 0, clear slv_valid, go to RESP.
  - Otherwise increment the counter. After timeout_cycles BUSY cycles with no ready: clear slv_valid, error = 1, data = 0, go to RESP.
  - Ready on the final counted cycle is a success.
- RESP: rsp_ready[granted] = 1 for exactly one cycle. rsp_rdata slices = captured data. rsp_error[granted] = error flag. Update the last-grant pointer. Go to IDLE.
- Ignore slv_ready outside BUSY and from non-selected slaves.
- No abort: a master dropping req_valid mid-transaction still receives its response.
- Counter width is $clog2(timeout_cycles+1) and it never wraps.
- Reset (asynchronous): state IDLE; all outputs 0; last-grant pointer set so data wins the first tie; counter 0. Asserting reset mid-BUSY drops slv_valid immediately, and no response is ever issued for that transaction.

## Timing
- Request sampled in IDLE at cycle 0 -> slv_valid high from cycle 1.
- Slave ready at cycle k (k >= 1) -> rsp_ready at cycle k+1. Minimum round trip is 2 cycles.
- Unmapped address: request at cycle 0 -> rsp_ready with error at cycle 1.
- Back-to-back: IDLE follows RESP, so the next grant is sampled the cycle after rsp_ready. There is at least one dead cycle between transactions.
- slv_valid never overlaps rsp_ready. At most one slv_valid bit is high at any time.

## Test plan
- Data read at 0x1000000, UART ready at cycle 3 with rdata 0x00000055 -> slv_valid = 4'b0010 on cycles 1-3; rsp_ready = 2'b10 at cycle 4; rsp_rdata[63:32] = 0x55; rsp_error = 0.
- After reset, fetch 0x40 and data 0x2000000 both valid at cycle 0, slaves ready immediately -> CLINT (data) served first, rsp at cycle 2. ROM (fetch) selected at cycle 4, rsp at cycle 5. On a repeated tie, data is granted next.
- Data write 0x30000000, wstrb 4'b1111 -> no slv_valid; rsp_ready[1] and rsp_error[1] at cycle 1; rdata 0.
- timeout_cycles = 8; read at 0x80000010 with slv_ready[3] held low -> slv_valid[3] high for exactly 8 cycles, then error response. Repeat with ready on the 8th cycle -> success.
- Write wstrb 4'b0011 to 0x200BFFC -> CLINT selected with slv_wstrb = 0011. Access to 0x200C000 -> error. Access to 0x7F -> ROM hit; access to 0x80 -> error.
- Reset asserted during BUSY -> slv_valid = 0 asynchronously and no rsp_ready. After release, a fetch to 0x0 completes normally.
